// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing the HI/LO pair, one bit of work per clock.
// Latency: WIDTH RUN cycles + 1 FIX cycle, done in cycle WIDTH+2; divide-by-zero done in cycle 1.
// Backpressure: none; start is ignored while busy, no queueing.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_div_q;
   logic               neg_res;   // product sign (mul) or quotient sign (div)
   logic               neg_rem;   // remainder follows the dividend's sign
   logic [WIDTH-1:0]   opnd;      // |multiplicand| or |divisor|
   logic [2*WIDTH-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Operand magnitudes, one shift-add / restoring-divide step, and final sign correction.
   always_comb begin
      abs_a    = (sgn && a[WIDTH-1]) ? -a : a;
      abs_b    = (sgn && b[WIDTH-1]) ? -b : b;

      // Carry out of the add is kept so the shift never loses the top product bit.
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc[WIDTH-1:1]};

      // Partial remainder can briefly need WIDTH+1 bits after the shift-in.
      rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, opnd});
      rem_sub  = rem_sh[WIDTH-1:0] - opnd;
      div_next = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};

      prod_fix = neg_res ? -acc : acc;
      quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Control FSM with registered busy/done/div_zero and the iteration datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_div_q <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start) begin
                  op_div_q <= op_div;
                  neg_res  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem  <= sgn & a[WIDTH-1];
                  opnd     <= abs_b;
                  acc      <= {{WIDTH{1'b0}}, abs_a};
                  cnt      <= CW'(WIDTH);
                  if (op_div && (b == '0)) begin
                     // No iterations: flag and finish immediately, hi/lo untouched.
                     state    <= DONE;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc <= op_div_q ? div_next : mul_next;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (op_div_q) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
